// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable width, parity and stop bits.
// Majority-vote sampling, start-glitch rejection, framing and break detection,
// and a valid/ready holding register that reports dropped frames as overrun.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] MID_C  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] MID_P1 = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic          ODD_MODE = (PARITY == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRK
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic                   rx_prev;
    logic [CW-1:0]          cnt;
    logic                   samp_a;
    logic                   samp_b;
    logic [3:0]             bit_idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic                   perr;
    logic                   ferr;

    logic                   maj;
    logic                   is_dec;
    logic                   is_wrap;
    logic                   last_stop;
    logic                   ferr_next;
    logic                   brk_cond;

    // Majority of the three mid-bit samples and the frame-completion terms.
    always_comb begin
        maj       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
        is_dec    = (cnt == MID_P1);
        is_wrap   = (cnt == LAST);
        last_stop = (STOP_BITS == 1) || stop_idx;
        ferr_next = ferr | ~maj;
        brk_cond  = (shreg == '0) && !par_bit && ferr_next;
    end

    // Two-flop synchroniser for the asynchronous line plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Receive FSM: bit timing, sampling, frame assembly and the output holding register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            samp_a       <= 1'b1;
            samp_b       <= 1'b1;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            break_det <= 1'b0;

            if (rx_valid && rx_ready) begin
                rx_valid     <= 1'b0;
                parity_error <= 1'b0;
                frame_error  <= 1'b0;
            end

            if (state != IDLE && state != BRK) begin
                cnt <= is_wrap ? '0 : cnt + 1'b1;
                if (cnt == MID_M1) samp_a <= rx_s;
                if (cnt == MID_C)  samp_b <= rx_s;
            end

            case (state)
                IDLE: begin
                    if (!rx_s && rx_prev) begin
                        cnt      <= '0;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        par_bit  <= 1'b0;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (is_dec && maj) begin
                        state <= IDLE;
                    end else if (is_wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (is_dec) begin
                        shreg <= {maj, shreg[DATA_BITS-1:1]};
                    end
                    if (is_wrap) begin
                        if (bit_idx == LAST_BIT) begin
                            state <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (is_dec) begin
                        par_bit <= maj;
                        perr    <= (^shreg) ^ maj ^ ODD_MODE;
                    end
                    if (is_wrap) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (is_dec) begin
                        ferr <= ferr_next;
                        if (last_stop) begin
                            if (brk_cond) begin
                                break_det <= 1'b1;
                                state     <= BRK;
                            end else begin
                                state <= IDLE;
                                if (!rx_valid || rx_ready) begin
                                    rx_data      <= shreg;
                                    parity_error <= perr;
                                    frame_error  <= ferr_next;
                                    rx_valid     <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end
                        end
                    end
                    if (is_wrap && !last_stop) begin
                        stop_idx <= 1'b1;
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: an 8E1 receiver driven from a vector
// table through a scoreboard, plus a 7O2 receiver for the alternate format.
module tb_uart_rx_cfg;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       ready_a = 1'b1;
    logic       ready_b = 1'b1;

    logic [7:0] data_a;
    logic       valid_a, perr_a, ferr_a, ovr_a, brk_a, busy_a;
    logic [6:0] data_b;
    logic       valid_b, perr_b, ferr_b, ovr_b, brk_b, busy_b;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        bit         flip_par;
        bit         bad_stop;
        int         glitch_bit;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    int   brk_cnt = 0;
    int   ovr_cnt = 0;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(rst_n), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(ready_a), .parity_error(perr_a), .frame_error(ferr_a),
        .overrun(ovr_a), .break_det(brk_a), .busy(busy_a)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(rst_n), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(ready_b), .parity_error(perr_b), .frame_error(ferr_b),
        .overrun(ovr_b), .break_det(brk_b), .busy(busy_b)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: counts pulses and compares every accepted word against the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (brk_a) brk_cnt++;
            if (ovr_a) ovr_cnt++;
            if (valid_a && ready_a) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word", data_a);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_val("rx_data", 32'(data_a), 32'(e.data));
                    check_val("parity_error", 32'(perr_a), 32'(e.perr));
                    check_val("frame_error", 32'(ferr_a), 32'(e.ferr));
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit_a(input logic b, input bit glitch);
        for (int c = 0; c < CPB; c++) begin
            @(posedge clk);
            #1;
            rx_a = (glitch && c == 5) ? ~b : b;
        end
    endtask

    // One 8E1 frame on rx_a; glitch_bit selects a wire bit to disturb for one clock.
    task automatic applyStimulus(input logic [7:0] d, input bit flip_par, input bit bad_stop,
                                 input int glitch_bit);
        logic [10:0] bits;
        bits = {~bad_stop, (^d) ^ flip_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            drive_bit_a(bits[i], glitch_bit == i);
        end
        @(posedge clk);
        #1;
        rx_a = 1'b1;
    endtask

    // One 7O2 frame on rx_b.
    task automatic send_b(input logic [6:0] d);
        logic [10:0] bits;
        bits = {2'b11, ~(^d), d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(posedge clk);
                #1;
                rx_b = bits[i];
            end
        end
    endtask

    task automatic checkOutput(input int max_cycles);
        for (int i = 0; i < max_cycles && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    endtask

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int brk0;
        int ovr0;
        bit seen;

        vecs[0] = '{8'hB3, 1'b0, 1'b0, -1, 8'hB3, 1'b0, 1'b0};
        vecs[1] = '{8'h12, 1'b1, 1'b0, -1, 8'h12, 1'b1, 1'b0};
        vecs[2] = '{8'h5A, 1'b0, 1'b1, -1, 8'h5A, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 1'b0, -1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h9F, 1'b0, 1'b0,  1, 8'h9F, 1'b0, 1'b0};
        vecs[5] = '{8'hC4, 1'b1, 1'b1, -1, 8'hC4, 1'b1, 1'b1};

        #1;
        check_val("reset_outputs_a", 32'({data_a, valid_a, perr_a, ferr_a, ovr_a, brk_a, busy_a}), 32'd0);
        check_val("reset_outputs_b", 32'({data_b, valid_b, perr_b, ferr_b, ovr_b, brk_b, busy_b}), 32'd0);
        cycles(3);
        rst_n = 1'b1;
        cycles(5);

        // Table-driven frames with the consumer always ready.
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back('{vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr});
            applyStimulus(vecs[i].d, vecs[i].flip_par, vecs[i].bad_stop, vecs[i].glitch_bit);
            checkOutput(40);
            cycles(4);
        end
        check_val("no_overrun_yet", 32'(ovr_cnt), 32'd0);
        check_val("no_break_yet", 32'(brk_cnt), 32'd0);

        // Alternate format: 7 data bits, odd parity, two stop bits.
        send_b(7'h33);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (valid_b) seen = 1'b1;
        end
        check_val("b_valid_seen", 32'(seen), 32'd1);
        check_val("b_rx_data", 32'(data_b), 32'h33);
        check_val("b_flags", 32'({perr_b, ferr_b}), 32'd0);
        @(negedge clk);
        check_val("b_valid_cleared", 32'(valid_b), 32'd0);

        // Overrun: consumer stalled across two back-to-back frames.
        @(posedge clk);
        #1;
        ready_a = 1'b0;
        ovr0 = ovr_cnt;
        sb_q.push_back('{8'h12, 1'b0, 1'b0});
        applyStimulus(8'h12, 1'b0, 1'b0, -1);
        applyStimulus(8'h33, 1'b0, 1'b0, -1);
        cycles(20);
        check_val("overrun_pulses", 32'(ovr_cnt - ovr0), 32'd1);
        check_val("held_valid", 32'(valid_a), 32'd1);
        check_val("held_data", 32'(data_a), 32'h12);
        ready_a = 1'b1;
        checkOutput(10);
        cycles(2);
        check_val("valid_dropped", 32'(valid_a), 32'd0);

        // Short start glitch must be rejected.
        rx_a = 1'b0;
        cycles(2);
        rx_a = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            if (busy_a) seen = 1'b1;
        end
        check_val("glitch_busy_rise", 32'(seen), 32'd1);
        cycles(12);
        check_val("glitch_idle", 32'({busy_a, valid_a, perr_a, ferr_a}), 32'd0);

        // Break: line held low for twelve bit periods.
        brk0 = brk_cnt;
        @(posedge clk);
        #1;
        rx_a = 1'b0;
        cycles(12 * CPB);
        check_val("break_pulses", 32'(brk_cnt - brk0), 32'd1);
        check_val("break_busy", 32'(busy_a), 32'd1);
        rx_a = 1'b1;
        cycles(5);
        check_val("break_released", 32'(busy_a), 32'd0);
        sb_q.push_back('{8'hFF, 1'b0, 1'b0});
        applyStimulus(8'hFF, 1'b0, 1'b0, -1);
        checkOutput(40);

        // Reset in the middle of a 0x00 frame.
        cycles(4);
        brk0 = brk_cnt;
        ovr0 = ovr_cnt;
        rx_a = 1'b0;
        cycles(3 * CPB);
        check_val("mid_frame_busy", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("reset_mid_frame", 32'({data_a, valid_a, perr_a, ferr_a, ovr_a, brk_a, busy_a}), 32'd0);
        rx_a = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(5);
        sb_q.push_back('{8'h9F, 1'b0, 1'b0});
        applyStimulus(8'h9F, 1'b0, 1'b0, -1);
        checkOutput(40);
        cycles(10);
        check_val("no_stale_pulses", 32'((brk_cnt - brk0) + (ovr_cnt - ovr0)), 32'd0);
        check_val("final_idle", 32'({busy_a, valid_a}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed-format uart_rx. It adds configurable data width, parity mode, stop-bit count and clocks-per-bit. It also adds majority-vote sampling, start-glitch rejection, framing/break detection and a valid/ready output holding register with overrun reporting. It sits between the serial pin and byte-level consumers (command decoder, FIFOs).

Parameters:
CLKS_PER_BIT, 4, clk cycles per bit period; must be >= 4.
DATA_BITS, 8, payload width; legal range 5..9.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
rx  input  1  serial line, idles high; asynchronous to clk.
rx_data  output  DATA_BITS  received payload; LSB is the first bit on the wire.
rx_valid  output  1  rx_data and error flags are valid.
rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready.
parity_error  output  1  parity mismatch for the held word; always 0 when PARITY=0.
frame_error  output  1  a stop bit was sampled low for the held word.
overrun  output  1  1-cycle pulse: a completed frame was dropped.
break_det  output  1  1-cycle pulse: break condition detected.
busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM IDLE, synchroniser flops and rx_prev set to 1. Reset mid-frame abandons the frame with no flags and no pulses.
- Input path: 2-flop synchroniser gives rx_s, plus a registered copy rx_prev.
- Bit timing:
  - Counter cnt runs 0..CLKS_PER_BIT-1 and wraps. MID = CLKS_PER_BIT/2.
  - rx_s is sampled at cnt = MID-1, MID and MID+1. The bit value is the majority of the three, decided at cnt = MID+1.
- FSM states: IDLE, START, DATA, PAR, STOP, BRK.
  - IDLE: a start is rx_s=0 && rx_prev=1 (falling edge only; a held-low line never starts a frame). On that cycle cnt<=0 and the FSM goes to START.
  - START: at decision point, majority 1 → IDLE (glitch rejected, no outputs). Majority 0 → continue; on cnt wrap go to DATA.
  - DATA: DATA_BITS bits shifted LSB-first, one per bit period. Then go to PAR if PARITY != 0, else STOP.
  - PAR: even mode expects XOR(data, parity bit) = 0; odd mode expects 1. A mismatch sets an internal perr.
  - STOP: STOP_BITS bits. Any stop sampled 0 sets an internal ferr. Completion occurs at the decision point of the last stop bit; the FSM leaves STOP there without waiting for the bit end, so the next start edge can be caught in the second half of the stop bit.
- Completion, evaluated in the completion cycle:
  - Break: data = 0, parity bit = 0 (if present) and ferr. Then break_det pulses next cycle, no word is delivered, the FSM goes to BRK, and BRK returns to IDLE on the first cycle rx_s=1.
  - Normal, holding register empty (rx_valid=0, or rx_valid && rx_ready in the same cycle): rx_data, parity_error and frame_error load and rx_valid=1 on the next cycle. Latency from the decision cycle is 1 clk.
  - Normal, register occupied and not being accepted: the new frame is discarded, overrun pulses 1 cycle, and the held word and flags are unchanged.
- Handshake: rx_valid stays high and rx_data/flags stay stable until the cycle rx_valid && rx_ready; rx_valid is 0 on the next cycle unless a new word loads in that same cycle. parity_error and frame_error are cleared together with rx_valid.
- busy = (state != IDLE).

Test Plan:
1. CLKS_PER_BIT=8, DATA_BITS=8, PARITY=1, rx_ready=1; send 0xB3 with correct even parity → one rx_valid pulse, rx_data=0xB3, parity_error=0, frame_error=0.
2. Same config, 0x12 with inverted parity bit → rx_data=0x12, parity_error=1. Then DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x33 → rx_data=7'h33, no errors.
3. rx_ready=0; send 0x12 then 0x33 back-to-back with one stop bit → rx_valid held, rx_data=0x12, overrun pulses exactly once. Raise rx_ready → rx_valid drops, no 0x33 ever appears.
4. Low glitch of 2 clks on idle line → busy rises then returns to 0 by start decision point, no rx_valid, no flags. Single-clk glitch on a data bit's middle sample of 0x9F → still 0x9F (majority).
5. Hold rx low for 12 bit periods → break_det pulses once, no rx_valid, busy stays 1 until release. Then send 0xFF → rx_data=0xFF, frame_error=0.
6. Assert reset during DATA of 0x00 frame → all outputs 0 immediately. Release and send 0x9F → rx_data=0x9F, with no stale flags or pulses.
